// File: rtl/sha256_round_ctrl.sv
// Control sequencer for one SHA-256 compression of a single 512-bit block.
// Walks IDLE -> LOAD -> ROUND x NUM_ROUNDS -> UPDATE -> DONE and drives the
// round-constant ROM address, the schedule select and the datapath strobes.
// Every output comes straight from a flop, so the datapath sees clean,
// glitch-free strobes with a fixed latency of 67 cycles from the start edge.
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64,  // compression rounds per block, at most 64
    parameter int MSG_WORDS  = 16   // rounds that take W straight from the block
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        first_block,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [5:0]  k_addr,
    output logic        w_sel,
    output logic        state_load,
    output logic        iv_sel,
    output logic        round_en,
    output logic        hash_update,
    output logic [15:0] blocks_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
    localparam logic [6:0] FIRST_EXP  = 7'(MSG_WORDS);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;          // round index; held at 0 outside ROUND
    logic        iv_latch_q, iv_latch_d;
    logic [15:0] blocks_cnt_q;

    logic busy_q, done_q, w_sel_q, state_load_q, iv_sel_q, round_en_q, hash_update_q;
    logic busy_d, done_d, w_sel_d, state_load_d, iv_sel_d, round_en_d, hash_update_d;

    // Next-state, round counter and IV-select latch decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        iv_latch_d = iv_latch_q;
        unique case (state_q)
            S_IDLE: begin
                // abort beats start; busy-time starts never reach this branch
                if (start && !abort) begin
                    state_d    = S_LOAD;
                    iv_latch_d = first_block;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = abort ? S_IDLE : S_ROUND;
            end
            S_ROUND: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_ROUND) begin
                    // stop exactly after the last round, never wrap into another
                    state_d = S_UPDATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_UPDATE: state_d = S_DONE;   // abort is deliberately ignored here
            S_DONE:   state_d = S_IDLE;   // start is not looked at in this cycle
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe.
    always_comb begin
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
        state_load_d  = (state_d == S_LOAD);
        iv_sel_d      = (state_d == S_LOAD) && iv_latch_d;
        round_en_d    = (state_d == S_ROUND);
        hash_update_d = (state_d == S_UPDATE);
        w_sel_d       = (state_d == S_ROUND) && ({1'b0, cnt_d} >= FIRST_EXP);
    end

    // State, round counter, IV latch and completed-block counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            iv_latch_q   <= 1'b0;
            blocks_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            iv_latch_q <= iv_latch_d;
            if (state_q == S_UPDATE) begin
                blocks_cnt_q <= blocks_cnt_q + 16'd1;  // wraps modulo 2^16
            end
        end
    end

    // Registered strobes and selects presented to the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            w_sel_q       <= 1'b0;
            state_load_q  <= 1'b0;
            iv_sel_q      <= 1'b0;
            round_en_q    <= 1'b0;
            hash_update_q <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            done_q        <= done_d;
            w_sel_q       <= w_sel_d;
            state_load_q  <= state_load_d;
            iv_sel_q      <= iv_sel_d;
            round_en_q    <= round_en_d;
            hash_update_q <= hash_update_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign k_addr      = cnt_q;
    assign w_sel       = w_sel_q;
    assign state_load  = state_load_q;
    assign iv_sel      = iv_sel_q;
    assign round_en    = round_en_q;
    assign hash_update = hash_update_q;
    assign blocks_cnt  = blocks_cnt_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl. Stimulus pushes one expected record
// per strobe cycle (LOAD, each ROUND, UPDATE, DONE) with its absolute cycle;
// an independent monitor pops and compares whenever any strobe is high.
module tb_sha256_round_ctrl;

    localparam int NR = 64;
    localparam int MW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        first_block = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, w_sel, state_load, iv_sel, round_en, hash_update;
    logic [5:0]  k_addr;
    logic [15:0] blocks_cnt;

    sha256_round_ctrl #(.NUM_ROUNDS(NR), .MSG_WORDS(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .first_block (first_block),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .k_addr      (k_addr),
        .w_sel       (w_sel),
        .state_load  (state_load),
        .iv_sel      (iv_sel),
        .round_en    (round_en),
        .hash_update (hash_update),
        .blocks_cnt  (blocks_cnt)
    );

    always #5 clk = ~clk;

    // strb order: {state_load, round_en, hash_update, done}
    typedef struct {
        int          cyc;
        logic [3:0]  strb;
        logic [5:0]  k;
        logic        w;
        logic        iv;
        logic [15:0] bcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Free-running cycle index: the period after edge n carries index n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    function automatic void push_evt(int c, logic [3:0] s, logic [5:0] k, logic w,
                                     logic iv, logic [15:0] b);
        exp_t e;
        e.cyc = c; e.strb = s; e.k = k; e.w = w; e.iv = iv; e.bcnt = b;
        exp_q.push_back(e);
    endfunction

    // Expected events for a block whose start is sampled at the edge opening
    // cycle s. last_k < NR-1 models a block cut short by abort or reset.
    function automatic void push_block(int s, logic fb, logic [15:0] bcnt, int last_k);
        push_evt(s, 4'b1000, 6'd0, 1'b0, fb, bcnt);
        for (int k = 0; k <= last_k; k++)
            push_evt(s + 1 + k, 4'b0100, 6'(k), (k >= MW), 1'b0, bcnt);
        if (last_k == NR - 1) begin
            push_evt(s + NR + 1, 4'b0010, 6'd0, 1'b0, 1'b0, bcnt);
            push_evt(s + NR + 2, 4'b0001, 6'd0, 1'b0, 1'b0, 16'(bcnt + 16'd1));
        end
    endfunction

    // Monitor: compare every strobe cycle against the head of the scoreboard.
    always @(negedge clk) begin : monitor
        logic [3:0] act;
        exp_t       e;
        act = {state_load, round_en, hash_update, done};
        if (!rst && act != 4'b0000) begin
            check("strobe_onehot", {31'd0, $onehot(act)}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {28'd0, act}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("evt_cycle",      cyc,                 e.cyc);
                check("evt_strobes",    {28'd0, act},        {28'd0, e.strb});
                check("evt_busy",       {31'd0, busy},       32'd1);
                check("evt_k_addr",     {26'd0, k_addr},     {26'd0, e.k});
                check("evt_w_sel",      {31'd0, w_sel},      {31'd0, e.w});
                if (e.strb[3]) check("evt_iv_sel", {31'd0, iv_sel}, {31'd0, e.iv});
                check("evt_blocks_cnt", {16'd0, blocks_cnt}, {16'd0, e.bcnt});
            end
        end
    end

    // Drive phase for all stimulus: 1 time unit after the falling edge.
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        for (int n = 0; n < 500 && cyc < c; n++) next_cycle();
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int n = 0; n < budget && exp_q.size() != 0; n++) next_cycle();
        check({name, "_drained"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic issue_start(input logic fb, input logic [15:0] bcnt, input int last_k,
                               output int s);
        s = cyc + 1;
        push_block(s, fb, bcnt, last_k);
        start       = 1'b1;
        first_block = fb;
        next_cycle();
        start       = 1'b0;
        first_block = 1'b0;
    endtask

    function automatic logic [31:0] all_outputs();
        return {7'd0, busy, done, w_sel, state_load, iv_sel, round_en, hash_update,
                k_addr, blocks_cnt[15:2], 2'b00} | {30'd0, blocks_cnt[1:0]};
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int s;
        #2 rst = 1'b1;
        repeat (3) next_cycle();
        check("reset_outputs", all_outputs(), 32'd0);
        rst = 1'b0;
        next_cycle();

        // Single block from the IV.
        issue_start(1'b1, 16'd0, NR - 1, s);
        wait_drain(100, "blk_first");
        next_cycle();
        check("idle_after_done", {31'd0, busy}, 32'd0);

        // Chained block: start raised in DONE (ignored) and held into IDLE.
        wait_drain(100, "blk_pre_chain");
        issue_start(1'b1, 16'd1, NR - 1, s);
        wait_drain(100, "blk_second_first");
        start = 1'b1; first_block = 1'b0;
        push_block(cyc + 2, 1'b0, 16'd2, NR - 1);
        next_cycle();
        next_cycle();
        start = 1'b0;
        wait_drain(100, "blk_chain");
        check("bcnt_after_chain", {16'd0, blocks_cnt}, 32'd3);

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        next_cycle();
        start = 1'b0; abort = 1'b0;
        next_cycle();
        check("start_abort_idle", {30'd0, busy, state_load}, 32'd0);

        // Abort during round 30.
        issue_start(1'b1, 16'd3, 30, s);
        wait_until(s + 31);
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        check("abort_busy",   {31'd0, busy},     32'd0);
        check("abort_k_addr", {26'd0, k_addr},   32'd0);
        check("abort_round",  {31'd0, round_en}, 32'd0);
        repeat (4) next_cycle();
        wait_drain(10, "blk_abort");
        check("abort_bcnt", {16'd0, blocks_cnt}, 32'd3);

        // Full block after abort; abort in UPDATE and DONE must be ignored.
        issue_start(1'b0, 16'd3, NR - 1, s);
        wait_until(s + NR + 1);
        abort = 1'b1;
        next_cycle();
        next_cycle();
        abort = 1'b0;
        wait_drain(100, "blk_abort_late");

        // start held high: one block per 68 cycles, nothing accepted while busy.
        next_cycle();
        start = 1'b1; first_block = 1'b1;
        push_block(cyc + 1, 1'b1, 16'd4, NR - 1);
        push_block(cyc + 1 + 68, 1'b1, 16'd5, NR - 1);
        wait_drain(200, "blk_held");
        start = 1'b0; first_block = 1'b0;
        repeat (3) next_cycle();
        check("held_idle", {31'd0, busy}, 32'd0);
        check("held_bcnt", {16'd0, blocks_cnt}, 32'd6);

        // Async reset between edges at round 50.
        issue_start(1'b1, 16'd6, 50, s);
        wait_until(s + 51);
        #1 rst = 1'b1;
        #1 check("async_rst_outputs", all_outputs(), 32'd0);
        wait_drain(1, "blk_reset");
        next_cycle();
        rst = 1'b0;
        next_cycle();
        issue_start(1'b1, 16'd0, NR - 1, s);
        wait_drain(100, "blk_after_rst");

        // Counter wrap: preload 0xFFFF, next UPDATE must give 0x0000.
        next_cycle();
        dut.blocks_cnt_q = 16'hFFFF;
        next_cycle();
        check("preload_bcnt", {16'd0, blocks_cnt}, 32'h0000_FFFF);
        issue_start(1'b0, 16'hFFFF, NR - 1, s);
        wait_drain(100, "blk_wrap");
        next_cycle();
        check("wrap_bcnt", {16'd0, blocks_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Sequencer for one SHA-256 compression of a single 512-bit block.
- Drives the 6-bit address of the round-constant ROM, the message-schedule select, and the load/enable strobes of the working-variable and hash-state registers.
- Sits between the block-level host handshake and the compression datapath.
- Completes one block per start pulse, with a fixed and deterministic latency.

Parameters:
- NUM_ROUNDS, 64, compression rounds per block. Must be at most 64 because the ROM address is 6 bits.
- MSG_WORDS, 16, rounds that take W directly from the message block. Later rounds take the expanded schedule word.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a block; sampled only in IDLE
- first_block  in  1  qualifies start. 1 = load the working registers from the IV; 0 = load them from the current hash state (chaining)
- abort  in  1  synchronous cancel of the block in flight
- busy  out  1  high from LOAD through DONE inclusive
- done  out  1  one-cycle pulse; hash state updated and valid
- k_addr  out  6  round-constant ROM address
- w_sel  out  1  0 = W from the message word, 1 = W from the schedule expander
- state_load  out  1  load working registers a..h
- iv_sel  out  1  with state_load: 1 = load IV, 0 = load hash state
- round_en  out  1  advance working registers and the schedule one round
- hash_update  out  1  H += a..h
- blocks_cnt  out  16  completed-block count, wraps modulo 2^16

Behaviour:
- Reset (async, rst=1): state=IDLE, round counter=0, iv_sel latch=0, blocks_cnt=0. All other outputs are 0.
- All outputs are registered (Moore).
- IDLE:
  - busy=0.
  - start=1 at a rising edge → LOAD. first_block is latched into iv_sel on the same edge.
  - start while busy=1 is ignored; no queuing.
- LOAD (1 cycle): state_load=1, iv_sel=latched value, round counter cleared to 0 → ROUND.
- ROUND (NUM_ROUNDS cycles):
  - round_en=1, k_addr=round counter, w_sel=(counter ≥ MSG_WORDS).
  - Counter increments each cycle.
  - When the counter reaches NUM_ROUNDS-1, the next state is UPDATE and the counter returns to 0. It never wraps through 63 into a 65th round.
- UPDATE (1 cycle): hash_update=1; blocks_cnt increments at the end of the cycle → DONE.
- DONE (1 cycle): done=1, busy=1 → IDLE.
  - A start asserted during DONE is ignored.
  - A new start is accepted the cycle after DONE.
- Latency with defaults, start sampled at edge 0:
  - LOAD in cycle 1.
  - ROUND in cycles 2–65, with k_addr 0..63.
  - UPDATE in cycle 66.
  - done in cycle 67.
  - Throughput: one block per 68 cycles, including the IDLE sample cycle.
- k_addr is 0 in every state other than ROUND. w_sel is 0 outside ROUND.
- Abort:
  - abort=1 in LOAD or ROUND → IDLE on the next edge. hash_update, done and blocks_cnt are not touched.
  - abort in UPDATE is ignored; the block completes.
  - abort in IDLE or DONE has no effect.
  - If start and abort are both high in IDLE, abort wins: remain IDLE.
- Async reset mid-block returns to IDLE immediately, without waiting for a clock edge. No done pulse, no hash_update.
- Strobe exclusivity: state_load, round_en and hash_update are never high together.

Test Plan:
- Single block, first_block=1:
  - start for 1 cycle → state_load=1, iv_sel=1 in cycle 1.
  - k_addr steps 0..63 in cycles 2–65.
  - w_sel=0 for k_addr 0–15 and 1 for 16–63.
  - hash_update in cycle 66; done pulse in cycle 67; blocks_cnt=1.
- Chained blocks: second start with first_block=0 the cycle after done → iv_sel=0 on state_load; blocks_cnt=2 after its done.
- Abort at k_addr=30 → next cycle busy=0, k_addr=0; no hash_update or done; blocks_cnt unchanged. A following start runs a full 64 rounds.
- start held high continuously → exactly one block per 68 cycles; no start accepted during busy or during the DONE cycle.
- Async rst asserted between clock edges at k_addr=50 → all outputs 0 before the next edge; after release, start runs a clean block starting at k_addr=0.
- blocks_cnt preloaded near wrap by running 65536 blocks (or forcing the register) → 0xFFFF goes to 0x0000 on the next UPDATE.
